adder54_share_arbiter: RTL and testbench

- Shares one 54+49-bit unsigned adder (55-bit sum) between NUM_REQ requesters.
- Round-robin arbitration, per-requester valid/ready on the request side, one shared response channel tagged with the requester id.
- Sits between the multiplier/normaliser requesters and a single adder instance; drives that adder's operand inputs and captures its sum.
- One operation in flight at a time.

---
 rtl/adder54_share_arbiter_if.sv | 28 ++
 rtl/adder54_share_arbiter.sv | 128 ++++++++++++
 tb/tb_adder54_share_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder54_share_arbiter_if.sv
// Bus bundle between the requesters, the shared 54+49 adder and the response consumer.
// The slave view belongs to the arbiter; the master view is everything around it.
interface adder54_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*54-1:0] req_a;
    logic [NUM_REQ*49-1:0] req_b;
    logic [53:0]           add_a;
    logic [53:0]           add_b;
    logic [54:0]           add_sum;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [54:0]           rsp_sum;

    modport slave (
        input  req_valid, req_a, req_b, add_sum, rsp_ready,
        output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
    );

    modport master (
        output req_valid, req_a, req_b, add_sum, rsp_ready,
        input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
    );
endinterface

// File: rtl/adder54_share_arbiter.sv
// Round-robin share of one 54+49-bit adder among NUM_REQ requesters.
// One operation in flight; a response is tagged with the owning requester id.
module adder54_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    adder54_share_arbiter_if.slave bus,
    output logic                   o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_gnt_id;
    logic [ID_W-1:0]    w_gnt;
    logic [ID_W-1:0]    w_rr_nxt;
    logic               w_found;
    logic               w_load;
    int                 w_idx;
    logic [NUM_REQ-1:0] w_req_ready;

    logic [53:0]        w_a [NUM_REQ];
    logic [48:0]        w_b [NUM_REQ];

    logic [53:0]        r_add_a;
    logic [53:0]        r_add_b;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [54:0]        r_rsp_sum;

    // Per-requester operand slices.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign w_a[gi] = bus.req_a[gi*54 +: 54];
        assign w_b[gi] = bus.req_b[gi*49 +: 49];
    end

    // Scan from rr_ptr upward, wrapping at NUM_REQ; first valid wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = ID_W'(w_idx);
            end
        end
    end

    assign w_rr_nxt = (int'(w_gnt) == NUM_REQ - 1) ? '0 : w_gnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_load) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP: begin
                if (bus.rsp_ready) w_state_nxt = w_load ? S_EXEC : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant is gated by reset so no handshake is signalled while rst_n is low.
    always_comb begin
        w_load      = 1'b0;
        w_req_ready = '0;
        if (rst_n && w_found) begin
            case (r_state)
                S_IDLE:  w_load = 1'b1;
                S_RESP:  w_load = bus.rsp_ready;
                default: w_load = 1'b0;
            endcase
        end
        if (w_load) w_req_ready[w_gnt] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_gnt_id    <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
        end else begin
            if (w_load) begin
                r_add_a  <= w_a[w_gnt];
                r_add_b  <= {5'b0, w_b[w_gnt]};
                r_gnt_id <= w_gnt;
                r_rr_ptr <= w_rr_nxt;
            end
            if (r_state == S_EXEC) begin
                r_rsp_sum   <= bus.add_sum;
                r_rsp_id    <= r_gnt_id;
                r_rsp_valid <= 1'b1;
            end else if (r_state == S_RESP && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.add_a     = r_add_a;
    assign bus.add_b     = r_add_b;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_sum   = r_rsp_sum;
    assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_adder54_share_arbiter.sv
// Directed and randomized checks of the shared-adder arbiter against a
// transaction-level model (round-robin scan, plain 55-bit addition).
module tb_adder54_share_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    always #5 clk = ~clk;

    adder54_share_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

    // Environment-side adder.
    assign bus.add_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b};

    adder54_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .o_busy (busy)
    );

    int          ncmp  = 0;
    int          nfail = 0;
    int          rr    = 0;
    int          bp    = -1;
    bit          fixed_ops = 1'b0;
    logic [53:0] ma [N];
    logic [48:0] mb [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int winner(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        rr = 0;
        tick();
    endtask

    // Offer every request in mask0 and drain them; granted requesters drop out.
    task automatic serve(input logic [N-1:0] mask0);
        logic [N-1:0] m;
        logic [N-1:0] oh;
        logic [53:0]  ea;
        logic [48:0]  eb;
        logic [54:0]  es;
        logic [63:0]  r;
        int           g;
        int           n;
        bit           more;
        m = mask0;
        for (int i = 0; i < N; i++) begin
            if (!fixed_ops) begin
                r = {$urandom(), $urandom()}; ma[i] = r[53:0];
                r = {$urandom(), $urandom()}; mb[i] = r[48:0];
            end
            bus.req_a[i*54 +: 54] = ma[i];
            bus.req_b[i*49 +: 49] = mb[i];
        end
        bus.req_valid = m;
        bus.rsp_ready = 1'b0;
        #1;
        g = winner(m);
        oh = '0; oh[g] = 1'b1;
        chk("grant_idle", 64'(bus.req_ready), 64'(oh));
        more = 1'b1;
        while (more) begin
            ea = ma[g];
            eb = mb[g];
            es = {1'b0, ea} + 55'(eb);
            tick();
            rr = (g + 1) % N;
            m[g] = 1'b0;
            bus.req_valid = m;
            bus.rsp_ready = 1'b0;
            r = {$urandom(), $urandom()};
            bus.req_a[g*54 +: 54] = r[53:0];
            #1;
            chk("exec_add_a", 64'(bus.add_a), 64'(ea));
            chk("exec_add_b", 64'(bus.add_b), {15'b0, eb});
            chk("exec_ready", 64'(bus.req_ready), 64'(0));
            chk("exec_busy", 64'(busy), 64'(1));
            chk("exec_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            tick();
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(1));
            chk("rsp_id", 64'(bus.rsp_id), 64'(g));
            chk("rsp_sum", 64'(bus.rsp_sum), 64'(es));
            n = (bp >= 0) ? bp : int'($urandom_range(0, 3));
            repeat (n) begin
                chk("bp_ready", 64'(bus.req_ready), 64'(0));
                tick();
                chk("bp_valid", 64'(bus.rsp_valid), 64'(1));
                chk("bp_id", 64'(bus.rsp_id), 64'(g));
                chk("bp_sum", 64'(bus.rsp_sum), 64'(es));
                chk("bp_busy", 64'(busy), 64'(1));
            end
            bus.rsp_ready = 1'b1;
            #1;
            if (m != '0) begin
                g = winner(m);
                oh = '0; oh[g] = 1'b1;
                chk("grant_b2b", 64'(bus.req_ready), 64'(oh));
            end else begin
                chk("last_ready", 64'(bus.req_ready), 64'(0));
                tick();
                bus.rsp_ready = 1'b0;
                chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'(0));
                chk("idle_busy", 64'(busy), 64'(0));
                more = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        #12;
        bus.req_valid = '1;
        #1;
        chk("rst_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_add_a", 64'(bus.add_a), 64'(0));
        chk("rst_add_b", 64'(bus.add_b), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
        chk("rst_rsp_sum", 64'(bus.rsp_sum), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        bus.req_valid = '0;
        tick();
        do_reset();

        // Single op on requester 1, held in RESP for two cycles.
        fixed_ops = 1'b1;
        ma[1] = 54'h3; mb[1] = 49'h5;
        bp = 2;
        serve(4'b0010);

        // Largest operands: carry-out set, B zero-extended.
        ma[2] = 54'h3FFFFFFFFFFFFF; mb[2] = 49'h1FFFFFFFFFFFF;
        bp = 0;
        serve(4'b0100);

        // All four requesting from a fresh pointer, back to back.
        do_reset();
        for (int i = 0; i < N; i++) begin
            ma[i] = 54'(i);
            mb[i] = 49'(10 * i);
        end
        serve(4'b1111);
        ma[0] = 54'h7; mb[0] = 49'h9;
        serve(4'b0001);

        // Backpressure with requester 2 pending behind requester 1.
        do_reset();
        bp = 5;
        serve(4'b0110);

        // Reset while an operation is in EXEC.
        do_reset();
        bus.req_a[0 +: 54] = 54'h123;
        bus.req_b[0 +: 49] = 49'h456;
        bus.req_valid = 4'b0001;
        #1;
        chk("mid_grant", 64'(bus.req_ready), 64'(1));
        tick();
        bus.req_valid = '0;
        #2;
        chk("mid_exec_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        bus.req_valid = 4'b0001;
        #1;
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_ready", 64'(bus.req_ready), 64'(0));
        chk("mid_rst_add_a", 64'(bus.add_a), 64'(0));
        bus.req_valid = '0;
        #2;
        rst_n = 1'b1;
        rr = 0;
        repeat (8) begin
            tick();
            chk("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            chk("post_rst_busy", 64'(busy), 64'(0));
        end

        // Randomized masks, operands and backpressure.
        fixed_ops = 1'b0;
        bp = -1;
        repeat (40) begin
            serve(4'($urandom_range(1, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
        $finish;
    end
endmodule
